// File: rtl/memwb_if.sv
// MEM->WB stage bundle: MEM-side control/data in, WB writeback and forwarding
// signals out, plus the stage's Stall/Flush controls.
interface memwb_if #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5
);
  // in_Valid qualifies the whole MEM bundle on every edge. There is no ready:
  // Stall is the only backpressure and, when high, the stage ignores the bundle.
  logic                 Stall;
  logic                 Flush;
  logic                 in_Valid;
  logic                 in_RegWrite;
  logic                 in_MemtoReg;
  logic [2:0]           in_LoadType;
  logic [DATA_W-1:0]    in_ALUResult;
  logic [REGADDR_W-1:0] in_RegDstOut;
  logic [DATA_W-1:0]    in_MemReadData;

  logic                 out_Valid;
  logic                 WB_RegWrite;
  logic [REGADDR_W-1:0] WB_RegDst;
  logic [DATA_W-1:0]    WB_WriteData;
  logic                 Hazard_RegWrite;
  logic [REGADDR_W-1:0] Hazard_RegDstOut;
  logic [31:0]          RetireCount;

  modport master (
    output Stall, Flush, in_Valid, in_RegWrite, in_MemtoReg, in_LoadType,
           in_ALUResult, in_RegDstOut, in_MemReadData,
    input  out_Valid, WB_RegWrite, WB_RegDst, WB_WriteData,
           Hazard_RegWrite, Hazard_RegDstOut, RetireCount
  );

  modport slave (
    input  Stall, Flush, in_Valid, in_RegWrite, in_MemtoReg, in_LoadType,
           in_ALUResult, in_RegDstOut, in_MemReadData,
    output out_Valid, WB_RegWrite, WB_RegDst, WB_WriteData,
           Hazard_RegWrite, Hazard_RegDstOut, RetireCount
  );
endinterface

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register with load-data extraction and writeback qualification.
// Optional retired-instruction counter enabled by macro MEMWB_RETIRE_CNT_EN.
module memwb_pipe #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5
) (
  input  logic     CLK,
  input  logic     RST,
  memwb_if.slave   bus
);
  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  logic                 valid_q;
  logic                 regwrite_q;
  logic                 memtoreg_q;
  logic [2:0]           loadtype_q;
  logic [DATA_W-1:0]    alu_q;
  logic [REGADDR_W-1:0] dst_q;
  logic [DATA_W-1:0]    mrd_q;

  // Flush only kills the control bits; data registers keep their contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      loadtype_q <= 3'd0;
      alu_q      <= '0;
      dst_q      <= '0;
      mrd_q      <= '0;
    end else if (bus.Flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (!bus.Stall) begin
      valid_q    <= bus.in_Valid;
      regwrite_q <= bus.in_RegWrite;
      memtoreg_q <= bus.in_MemtoReg;
      loadtype_q <= bus.in_LoadType;
      alu_q      <= bus.in_ALUResult;
      dst_q      <= bus.in_RegDstOut;
      mrd_q      <= bus.in_MemReadData;
    end
  end

  logic [OFF_W-1:0]  off;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] word_sx;
  logic [DATA_W-1:0] word_zx;
  logic [DATA_W-1:0] load_v;

  assign off    = alu_q[OFF_W-1:0];
  assign byte_v = mrd_q[{off, 3'b000} +: 8];
  assign half_v = mrd_q[{off[OFF_W-1:1], 4'b0000} +: 16];

  // 32-bit word loads only exist on the 64-bit datapath; otherwise full word.
  generate
    if (DATA_W == 64) begin : g_word64
      logic [31:0] word_v;
      assign word_v  = mrd_q[{off[OFF_W-1], 5'b00000} +: 32];
      assign word_sx = {{(DATA_W-32){word_v[31]}}, word_v};
      assign word_zx = {{(DATA_W-32){1'b0}}, word_v};
    end else begin : g_word32
      assign word_sx = mrd_q;
      assign word_zx = mrd_q;
    end
  endgenerate

  always_comb begin
    load_v = mrd_q;
    case (loadtype_q)
      3'd1:    load_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'd2:    load_v = {{(DATA_W-8){1'b0}}, byte_v};
      3'd3:    load_v = {{(DATA_W-16){half_v[15]}}, half_v};
      3'd4:    load_v = {{(DATA_W-16){1'b0}}, half_v};
      3'd5:    load_v = word_sx;
      3'd6:    load_v = word_zx;
      default: load_v = mrd_q;
    endcase
  end

  logic wb_we;
  assign wb_we = regwrite_q & valid_q & (dst_q != '0);

  assign bus.out_Valid        = valid_q;
  assign bus.WB_RegWrite      = wb_we;
  assign bus.WB_RegDst        = dst_q;
  assign bus.WB_WriteData     = memtoreg_q ? load_v : alu_q;
  assign bus.Hazard_RegWrite  = wb_we;
  assign bus.Hazard_RegDstOut = dst_q;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [31:0] retire_q;
  // An instruction retires when it leaves WB: valid and the stage advances.
  always_ff @(posedge CLK) begin
    if (RST)
      retire_q <= 32'd0;
    else if (valid_q && (!bus.Stall || bus.Flush))
      retire_q <= retire_q + 32'd1;
  end
  assign bus.RetireCount = retire_q;
`else
  assign bus.RetireCount = 32'd0;
`endif
endmodule

// File: tb/tb_memwb_pipe.sv
// Randomized self-checking bench for memwb_pipe, 32- and 64-bit instances
// compared against a behavioural stage model.
module tb_memwb_pipe;
  logic CLK = 1'b0;
  logic rst, stall, flush;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [63:0] alu;
    logic [4:0]  dst;
    logic [63:0] mrd;
  } mem_t;

  mem_t in32, in64, m32, m64;
  logic [31:0] cnt32, cnt64;

  memwb_if #(.DATA_W(32), .REGADDR_W(5)) bus32 ();
  memwb_if #(.DATA_W(64), .REGADDR_W(5)) bus64 ();

  assign bus32.Stall          = stall;
  assign bus32.Flush          = flush;
  assign bus32.in_Valid       = in32.valid;
  assign bus32.in_RegWrite    = in32.rw;
  assign bus32.in_MemtoReg    = in32.m2r;
  assign bus32.in_LoadType    = in32.lt;
  assign bus32.in_ALUResult   = in32.alu[31:0];
  assign bus32.in_RegDstOut   = in32.dst;
  assign bus32.in_MemReadData = in32.mrd[31:0];

  assign bus64.Stall          = stall;
  assign bus64.Flush          = flush;
  assign bus64.in_Valid       = in64.valid;
  assign bus64.in_RegWrite    = in64.rw;
  assign bus64.in_MemtoReg    = in64.m2r;
  assign bus64.in_LoadType    = in64.lt;
  assign bus64.in_ALUResult   = in64.alu;
  assign bus64.in_RegDstOut   = in64.dst;
  assign bus64.in_MemReadData = in64.mrd;

  memwb_pipe #(.DATA_W(32), .REGADDR_W(5)) dut32 (.CLK(CLK), .RST(rst), .bus(bus32.slave));
  memwb_pipe #(.DATA_W(64), .REGADDR_W(5)) dut64 (.CLK(CLK), .RST(rst), .bus(bus64.slave));

  function automatic mem_t mdl_next(mem_t s, mem_t i, logic r, logic st, logic fl);
    mem_t n = s;
    if (r) n = '0;
    else if (fl) begin n.valid = 1'b0; n.rw = 1'b0; n.m2r = 1'b0; end
    else if (!st) n = i;
    return n;
  endfunction

  function automatic logic [63:0] exp_wd(mem_t s, int dw);
    logic [63:0] v;
    int off;
    off = (dw == 64) ? int'(s.alu[2:0]) : int'(s.alu[1:0]);
    if (!s.m2r) v = s.alu;
    else begin
      case (s.lt)
        3'd1: begin v = (s.mrd >> (off*8)) & 64'hFF; if (v[7]) v = v | ~64'hFF; end
        3'd2: v = (s.mrd >> (off*8)) & 64'hFF;
        3'd3: begin v = (s.mrd >> ((off/2)*16)) & 64'hFFFF; if (v[15]) v = v | ~64'hFFFF; end
        3'd4: v = (s.mrd >> ((off/2)*16)) & 64'hFFFF;
        3'd5: if (dw == 64) begin
                v = (s.mrd >> ((off/4)*32)) & 64'hFFFF_FFFF;
                if (v[31]) v = v | 64'hFFFF_FFFF_0000_0000;
              end else v = s.mrd;
        3'd6: if (dw == 64) v = (s.mrd >> ((off/4)*32)) & 64'hFFFF_FFFF;
              else v = s.mrd;
        default: v = s.mrd;
      endcase
    end
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic exp_we(mem_t s);
    return s.rw && s.valid && (s.dst != 5'd0);
  endfunction

  function automatic logic [31:0] exp_cnt(logic [31:0] c);
`ifdef MEMWB_RETIRE_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  function automatic mem_t rand_mem(int dw);
    mem_t r;
    r.valid = 1'($urandom_range(0, 1));
    r.rw    = 1'($urandom_range(0, 1));
    r.m2r   = 1'($urandom_range(0, 1));
    r.lt    = 3'($urandom_range(0, 7));
    r.alu   = {$urandom, $urandom};
    r.mrd   = {$urandom, $urandom};
    r.dst   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    if (dw == 32) begin
      r.alu = r.alu & 64'hFFFF_FFFF;
      r.mrd = r.mrd & 64'hFFFF_FFFF;
    end
    return r;
  endfunction

  // One clock edge: advance the model with the inputs held across the edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge CLK);
    if (rst) begin cnt32 = 0; cnt64 = 0; end
    else begin
      if (m32.valid && (!stall || flush)) cnt32 = cnt32 + 1;
      if (m64.valid && (!stall || flush)) cnt64 = cnt64 + 1;
    end
    m32 = mdl_next(m32, in32, rst, stall, flush);
    m64 = mdl_next(m64, in64, rst, stall, flush);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'($urandom_range(0, 1));
    flush = 1'($urandom_range(0, 1));
    in32 = rand_mem(32);
    in64 = rand_mem(64);
    tick();
    tick();
    total++; if ({bus32.out_Valid, bus32.WB_RegWrite, bus32.Hazard_RegWrite} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl32 got=%b want=000", {bus32.out_Valid, bus32.WB_RegWrite, bus32.Hazard_RegWrite}); end
    total++; if ({bus32.WB_RegDst, bus32.Hazard_RegDstOut, bus32.WB_WriteData} !== 42'd0) begin
      bad++; $display("FAIL reset_data32 dst=%0d hdst=%0d wd=%h want=0", bus32.WB_RegDst, bus32.Hazard_RegDstOut, bus32.WB_WriteData); end
    total++; if (bus32.RetireCount !== 32'd0) begin
      bad++; $display("FAIL reset_cnt32 got=%0d want=0", bus32.RetireCount); end
    total++; if ({bus64.out_Valid, bus64.WB_RegWrite, bus64.WB_WriteData} !== 66'd0) begin
      bad++; $display("FAIL reset_64 v=%b we=%b wd=%h want=0", bus64.out_Valid, bus64.WB_RegWrite, bus64.WB_WriteData); end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load_vectors();
    in32 = '0; in32.valid = 1; in32.rw = 1; in32.m2r = 1; in32.lt = 3'd1;
    in32.alu = 64'h1002; in32.mrd = 64'h80FF7F01; in32.dst = 5'd7;
    tick();
    total++; if (bus32.WB_WriteData !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL lb_sign got=%h want=ffffffff", bus32.WB_WriteData); end
    total++; if (bus32.WB_RegWrite !== 1'b1) begin
      bad++; $display("FAIL lb_we got=%b want=1", bus32.WB_RegWrite); end
    in32.lt = 3'd4;
    tick();
    total++; if (bus32.WB_WriteData !== 32'h0000_80FF) begin
      bad++; $display("FAIL lhu got=%h want=000080ff", bus32.WB_WriteData); end
    in32.lt = 3'd3; in32.alu = 64'h1003;
    tick();
    total++; if (bus32.WB_WriteData !== 32'hFFFF_80FF) begin
      bad++; $display("FAIL lh_misalign got=%h want=ffff80ff", bus32.WB_WriteData); end
    in32.lt = 3'd5;
    tick();
    total++; if (bus32.WB_WriteData !== 32'h80FF_7F01) begin
      bad++; $display("FAIL lw_on32 got=%h want=80ff7f01", bus32.WB_WriteData); end
  endtask

  task automatic test_reg0();
    in32 = '0; in32.valid = 1; in32.rw = 1; in32.dst = 5'd0; in32.alu = 64'h55;
    tick();
    total++; if ({bus32.WB_RegWrite, bus32.Hazard_RegWrite} !== 2'b00) begin
      bad++; $display("FAIL reg0_we got=%b want=00", {bus32.WB_RegWrite, bus32.Hazard_RegWrite}); end
    total++; if (bus32.out_Valid !== 1'b1) begin
      bad++; $display("FAIL reg0_valid got=%b want=1", bus32.out_Valid); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] hold_wd;
    in32 = '0; in32.valid = 1; in32.rw = 1; in32.m2r = 1; in32.lt = 3'd2;
    in32.alu = 64'h2001; in32.mrd = 64'hA1B2C3D4; in32.dst = 5'd9;
    tick();
    hold_wd = 32'h0000_00C3;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in32 = rand_mem(32);
      tick();
      total++; if ({bus32.out_Valid, bus32.WB_RegWrite, bus32.WB_RegDst, bus32.WB_WriteData} !== {1'b1, 1'b1, 5'd9, hold_wd}) begin
        bad++; $display("FAIL stall_hold%0d v=%b we=%b dst=%0d wd=%h want 1 1 9 %h", i,
          bus32.out_Valid, bus32.WB_RegWrite, bus32.WB_RegDst, bus32.WB_WriteData, hold_wd); end
    end
    flush = 1'b1;
    tick();
    total++; if ({bus32.out_Valid, bus32.WB_RegWrite} !== 2'b00) begin
      bad++; $display("FAIL stall_flush v=%b we=%b want 0 0", bus32.out_Valid, bus32.WB_RegWrite); end
    total++; if ({bus32.WB_RegDst, bus32.WB_WriteData} !== {5'd9, 32'h2001}) begin
      bad++; $display("FAIL flush_keeps_data dst=%0d wd=%h want 9 00002001", bus32.WB_RegDst, bus32.WB_WriteData); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load64();
    in64 = '0; in64.valid = 1; in64.rw = 1; in64.m2r = 1; in64.lt = 3'd5;
    in64.alu = 64'h4004; in64.mrd = 64'h8000_0001_0000_0000; in64.dst = 5'd3;
    tick();
    total++; if (bus64.WB_WriteData !== 64'hFFFF_FFFF_8000_0001) begin
      bad++; $display("FAIL lw64 got=%h want=ffffffff80000001", bus64.WB_WriteData); end
    in64.lt = 3'd6;
    tick();
    total++; if (bus64.WB_WriteData !== 64'h0000_0000_8000_0001) begin
      bad++; $display("FAIL lwu64 got=%h want=0000000080000001", bus64.WB_WriteData); end
    in64.lt = 3'd1; in64.alu = 64'h4007;
    tick();
    total++; if (bus64.WB_WriteData !== 64'hFFFF_FFFF_FFFF_FF80) begin
      bad++; $display("FAIL lb64_lane7 got=%h want=ffffffffffffff80", bus64.WB_WriteData); end
  endtask

  task automatic test_random();
    logic [63:0] w64, w32;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      in32  = rand_mem(32);
      in64  = rand_mem(64);
      tick();
      w32 = exp_wd(m32, 32);
      w64 = exp_wd(m64, 64);
      total++; if ({bus32.out_Valid, bus32.WB_RegWrite, bus32.Hazard_RegWrite, bus32.WB_RegDst, bus32.Hazard_RegDstOut}
                   !== {m32.valid, exp_we(m32), exp_we(m32), m32.dst, m32.dst}) begin
        bad++; $display("FAIL rand_ctrl32 n=%0d v=%b we=%b hwe=%b dst=%0d hdst=%0d want v=%b we=%b dst=%0d", n,
          bus32.out_Valid, bus32.WB_RegWrite, bus32.Hazard_RegWrite, bus32.WB_RegDst, bus32.Hazard_RegDstOut,
          m32.valid, exp_we(m32), m32.dst); end
      total++; if ({32'd0, bus32.WB_WriteData} !== w32) begin
        bad++; $display("FAIL rand_wd32 n=%0d lt=%0d got=%h want=%h", n, m32.lt, bus32.WB_WriteData, w32); end
      total++; if ({bus64.out_Valid, bus64.WB_RegWrite, bus64.Hazard_RegDstOut} !== {m64.valid, exp_we(m64), m64.dst}) begin
        bad++; $display("FAIL rand_ctrl64 n=%0d v=%b we=%b hdst=%0d want v=%b we=%b dst=%0d", n,
          bus64.out_Valid, bus64.WB_RegWrite, bus64.Hazard_RegDstOut, m64.valid, exp_we(m64), m64.dst); end
      total++; if (bus64.WB_WriteData !== w64) begin
        bad++; $display("FAIL rand_wd64 n=%0d lt=%0d got=%h want=%h", n, m64.lt, bus64.WB_WriteData, w64); end
      total++; if ({bus32.RetireCount, bus64.RetireCount} !== {exp_cnt(cnt32), exp_cnt(cnt64)}) begin
        bad++; $display("FAIL rand_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, bus32.RetireCount, bus64.RetireCount,
          exp_cnt(cnt32), exp_cnt(cnt64)); end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_retire();
    logic [31:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in32 = rand_mem(32);
      in32.valid = (k < 6);
      flush = (k == 3);
      tick();
    end
    flush = 1'b0;
`ifdef MEMWB_RETIRE_CNT_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    total++; if (bus32.RetireCount !== want) begin
      bad++; $display("FAIL retire_five got=%0d want=%0d", bus32.RetireCount, want); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (bus32.RetireCount !== 32'd0) begin
      bad++; $display("FAIL retire_rst got=%0d want=0", bus32.RetireCount); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in32 = '0; in64 = '0; m32 = '0; m64 = '0; cnt32 = 0; cnt64 = 0;
    @(negedge CLK);
    test_reset();
    test_load_vectors();
    test_reg0();
    test_stall_flush();
    test_load64();
    test_random();
    test_retire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memwb_pipe.md
MEMWB_PIPE -- requirements
Module: memwb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter REGADDR_W, default 5, register-address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous reset, active-high.
REQ-004 The block SHALL have these ports, in addition to CLK and RST:
- Stall  in  1  hold all stage registers.
- Flush  in  1  insert bubble.
- in_Valid  in  1  MEM-stage instruction valid.
- in_RegWrite  in  1  MEM control.
- in_MemtoReg  in  1  MEM control.
- in_LoadType  in  3  load-extraction code.
- in_ALUResult  in  DATA_W  ALU result or address.
- in_RegDstOut  in  REGADDR_W  destination register.
- in_MemReadData  in  DATA_W  raw memory word.
- out_Valid  out  1  WB-stage valid.
- WB_RegWrite  out  1  qualified write enable.
- WB_RegDst  out  REGADDR_W  write address.
- WB_WriteData  out  DATA_W  write data.
- Hazard_RegWrite  out  1  forwarding enable.
- Hazard_RegDstOut  out  REGADDR_W  forwarding address.
- RetireCount  out  32  retired-instruction count (feature-dependent).

Function
REQ-005 The block SHALL register Valid, RegWrite, MemtoReg, LoadType, ALUResult, RegDstOut and MemReadData each cycle when Stall=0 and Flush=0.
- Latency from MEM inputs to WB outputs is 1 cycle.
REQ-006 Flush=1 SHALL clear the registered Valid, RegWrite and MemtoReg on the next edge and leave the data registers unchanged; Flush has priority over Stall.
REQ-007 Stall=1 with Flush=0 SHALL hold every register unchanged.
REQ-008 WB_RegWrite SHALL equal registered RegWrite AND Valid AND (RegDstOut != 0); writes to register 0 are suppressed.
REQ-009 WB_RegDst SHALL equal the registered RegDstOut.
REQ-010 Hazard_RegWrite SHALL equal WB_RegWrite, and Hazard_RegDstOut SHALL equal the registered RegDstOut.
REQ-011 WB_WriteData SHALL be combinational from the registered values:
- MemtoReg=0: ALUResult.
- MemtoReg=1: the extracted load value.
REQ-012 The lane offset SHALL be ALUResult[1:0] for DATA_W=32 and ALUResult[2:0] for DATA_W=64; lane 0 holds the least-significant byte.
REQ-013 Load extraction by LoadType:
- 0: full word.
- 1: LB, sign-extended byte at offset.
- 2: LBU, zero-extended byte at offset.
- 3: LH, sign-extended halfword at offset with offset bit 0 ignored.
- 4: LHU, zero-extended halfword.
- 5: LW, sign-extended 32-bit at offset bit 2, DATA_W=64 only.
- 6: LWU, zero-extended 32-bit, DATA_W=64 only.
- 7, or 5/6 with DATA_W=32: full word.
REQ-014 A misaligned halfword or word offset SHALL NOT raise an exception; the low offset bits are ignored.
REQ-015 Stall and Flush asserted during the RST cycle SHALL be ignored.

Reset
REQ-016 RST=1 at a rising edge SHALL clear all registers to 0; afterwards out_Valid=0, WB_RegWrite=0, WB_RegDst=0, WB_WriteData=0, Hazard_*=0 and RetireCount=0.
REQ-017 Reset asserted mid-stall SHALL override the stall and discard the held instruction.

Configuration
REQ-018 Macro MEMWB_RETIRE_CNT_EN defined: RetireCount SHALL increment by 1 on each edge where out_Valid=1 and the stage advances (Stall=0 or Flush=1).
- Wraps 0xFFFFFFFF -> 0.
- Cleared by RST.
REQ-019 Macro MEMWB_RETIRE_CNT_EN undefined: RetireCount SHALL be tied to 0 and no counter register SHALL be present.

Verification
REQ-020 Load, MEM: RegWrite=1, MemtoReg=1, LoadType=1, ALUResult=0x1002, MemReadData=0x80FF7F01 -> next cycle WB_WriteData=0xFFFFFFFF, WB_RegWrite=1.
REQ-021 Same load with LoadType=4 and ALUResult=0x1002 -> WB_WriteData=0x000080FF.
REQ-022 Valid write to RegDstOut=0 -> WB_RegWrite=0 and Hazard_RegWrite=0.
REQ-023 Stall=1 for 3 cycles while the inputs change -> WB outputs constant; Stall and Flush both 1 -> out_Valid=0 the next cycle.
REQ-024 DATA_W=64 LoadType=5, ALUResult[2:0]=4, MemReadData=0x8000000100000000 -> WB_WriteData=0xFFFFFFFF80000001.
REQ-025 With MEMWB_RETIRE_CNT_EN: 5 valid instructions with one flushed bubble -> RetireCount=5; RST -> 0.
